// File: rtl/button_event_decoder_if.sv
// Button event bus: the debounced level goes in, the decoded event pulses
// and the held level come out.
interface button_event_decoder_if;
  logic clean;
  logic press;
  // release and repeat are reserved words, so those two pulses carry an _evt suffix
  logic release_evt;
  logic long_press;
  logic repeat_evt;
  logic single_click;
  logic double_click;
  logic held;

  modport master (
    output clean,
    input  press, release_evt, long_press, repeat_evt,
    input  single_click, double_click, held
  );

  modport slave (
    input  clean,
    output press, release_evt, long_press, repeat_evt,
    output single_click, double_click, held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release, long-press, auto-repeat,
// single-click and double-click pulses, all registered.
module button_event_decoder #(
  parameter int unsigned LONG_DELAY    = 32500000,
  parameter int unsigned REPEAT_DELAY  = 6500000,
  parameter int unsigned DCLICK_WINDOW = 19500000,
  parameter int unsigned NBITS         = 26
) (
  input  logic                  clock,
  input  logic                  reset,
  button_event_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HELD, LONG, WAIT2} state_t;

  localparam logic [NBITS-1:0] ONE         = NBITS'(1);
  localparam logic [NBITS-1:0] LONG_LAST   = NBITS'(LONG_DELAY - 1);
  localparam logic [NBITS-1:0] REPEAT_LAST = NBITS'(REPEAT_DELAY - 1);
  localparam logic [NBITS-1:0] DCLICK_LAST = NBITS'(DCLICK_WINDOW - 1);

  state_t           state;
  logic [NBITS-1:0] count;
  logic             second;
  logic             prev;
  logic             rise;
  logic             fall;

  assign rise = bus.clean & ~prev;
  assign fall = ~bus.clean & prev;

  // NOTE: all state and outputs live in one clocked block with non-blocking
  // assignments, so every branch reads the values from before this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      second           <= 1'b0;
      // Reset to "pressed" so a button held through reset needs a fresh press.
      prev             <= 1'b1;
      bus.press        <= 1'b0;
      bus.release_evt  <= 1'b0;
      bus.long_press   <= 1'b0;
      bus.repeat_evt   <= 1'b0;
      bus.single_click <= 1'b0;
      bus.double_click <= 1'b0;
      bus.held         <= 1'b0;
    end else begin
      prev             <= bus.clean;
      bus.press        <= 1'b0;
      bus.release_evt  <= 1'b0;
      bus.long_press   <= 1'b0;
      bus.repeat_evt   <= 1'b0;
      bus.single_click <= 1'b0;
      bus.double_click <= 1'b0;

      unique case (state)
        IDLE: begin
          count    <= '0;
          bus.held <= rise;
          if (rise) begin
            bus.press <= 1'b1;
            second    <= 1'b0;
            state     <= HELD;
          end
        end

        HELD: begin
          // A release on the long-press boundary still counts as a short press.
          if (fall) begin
            bus.release_evt <= 1'b1;
            bus.held        <= 1'b0;
            count           <= '0;
            state           <= second ? IDLE : WAIT2;
          end else if (count == LONG_LAST) begin
            bus.long_press <= 1'b1;
            bus.held       <= 1'b1;
            count          <= '0;
            state          <= LONG;
          end else begin
            bus.held <= 1'b1;
            count    <= count + ONE;
          end
        end

        LONG: begin
          if (fall) begin
            bus.release_evt <= 1'b1;
            bus.held        <= 1'b0;
            count           <= '0;
            state           <= IDLE;
          end else if (count == REPEAT_LAST) begin
            bus.repeat_evt <= 1'b1;
            bus.held       <= 1'b1;
            count          <= '0;
          end else begin
            bus.held <= 1'b1;
            count    <= count + ONE;
          end
        end

        WAIT2: begin
          bus.held <= rise;
          // A rise on the timeout cycle beats the single-click timeout.
          if (rise) begin
            bus.press        <= 1'b1;
            bus.double_click <= 1'b1;
            second           <= 1'b1;
            count            <= '0;
            state            <= HELD;
          end else if (count == DCLICK_LAST) begin
            bus.single_click <= 1'b1;
            count            <= '0;
            state            <= IDLE;
          end else begin
            count <= count + ONE;
          end
        end

        default: begin
          bus.held <= 1'b0;
          count    <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: directed scenarios plus random button traffic, checked
// against a timestamp-based model of the event rules.
module tb_button_event_decoder;

  localparam int LD = 8;
  localparam int RD = 3;
  localparam int DW = 5;
  localparam int NB = 8;

  typedef struct packed {
    logic press;
    logic release_evt;
    logic long_press;
    logic repeat_evt;
    logic single_click;
    logic double_click;
    logic held;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  button_event_decoder_if bus ();

  button_event_decoder #(
    .LONG_DELAY   (LD),
    .REPEAT_DELAY (RD),
    .DCLICK_WINDOW(DW),
    .NBITS        (NB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: the button is either tracked as down (since edge t_press) or
  // awaiting a second press (since short release at edge t_rel).
  bit m_active = 1'b0;
  bit m_wait   = 1'b0;
  bit m_second = 1'b0;
  bit m_prev   = 1'b1;
  int t_press  = 0;
  int t_rel    = 0;
  int edge_n   = 0;

  function automatic ev_t observed();
    ev_t o;
    o.press        = bus.press;
    o.release_evt  = bus.release_evt;
    o.long_press   = bus.long_press;
    o.repeat_evt   = bus.repeat_evt;
    o.single_click = bus.single_click;
    o.double_click = bus.double_click;
    o.held         = bus.held;
    return o;
  endfunction

  task automatic check(input string tag, input ev_t exp);
    ev_t obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got(p,r,l,rp,s,d,h)=%b want=%b", tag, edge_n, obs, exp);
    end
  endtask

  // Drive one sampled value of clean, then check the cycle that follows the edge.
  task automatic step(input logic c, input string tag);
    ev_t exp;
    bit  rise;
    bit  fall;
    int  d;
    int  e;
    bus.clean = c;
    @(posedge clock);
    edge_n++;
    rise   = c && !m_prev;
    fall   = !c && m_prev;
    m_prev = c;
    exp    = '0;
    if (m_active) begin
      d = edge_n - t_press;
      if (fall) begin
        exp.release_evt = 1'b1;
        m_active = 1'b0;
        if (d <= LD && !m_second) begin
          m_wait = 1'b1;
          t_rel  = edge_n;
        end
      end else if (d == LD) begin
        exp.long_press = 1'b1;
      end else if (d > LD && (d - LD) % RD == 0) begin
        exp.repeat_evt = 1'b1;
      end
    end else if (m_wait) begin
      e = edge_n - t_rel;
      if (rise) begin
        exp.press        = 1'b1;
        exp.double_click = 1'b1;
        m_wait   = 1'b0;
        m_active = 1'b1;
        m_second = 1'b1;
        t_press  = edge_n;
      end else if (e == DW) begin
        exp.single_click = 1'b1;
        m_wait = 1'b0;
      end
    end else if (rise) begin
      exp.press = 1'b1;
      m_active  = 1'b1;
      m_second  = 1'b0;
      t_press   = edge_n;
    end
    exp.held = m_active;
    #1 check(tag, exp);
  endtask

  task automatic hold(input logic c, input int n, input string tag);
    for (int i = 0; i < n; i++) step(c, tag);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic apply_reset(input logic c, input string tag);
    @(negedge clock);
    #2;
    bus.clean = c;
    reset     = 1'b1;
    m_active  = 1'b0;
    m_wait    = 1'b0;
    m_second  = 1'b0;
    m_prev    = 1'b1;
    #1 check({tag, "_async"}, '0);
    repeat (2) @(posedge clock);
    #1 check({tag, "_during"}, '0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.clean = 1'b0;
    apply_reset(1'b0, "rst");

    // Short press then single click after the window.
    hold(1'b1, 4, "s1_hold");
    hold(1'b0, 8, "s1_rel");

    // Long hold with repeats.
    hold(1'b1, 20, "s2_hold");
    hold(1'b0, 8, "s2_rel");

    // Double click, re-press two cycles after release.
    hold(1'b1, 3, "s3_p1");
    hold(1'b0, 2, "s3_gap");
    hold(1'b1, 3, "s3_p2");
    hold(1'b0, 8, "s3_rel");

    // Re-press exactly on the window timeout.
    hold(1'b1, 2, "s4_p1");
    hold(1'b0, DW, "s4_gap");
    hold(1'b1, 2, "s4_p2");
    hold(1'b0, 8, "s4_rel");

    // Re-press one cycle after the timeout: single click, then a fresh press.
    hold(1'b1, 2, "late_p1");
    hold(1'b0, DW + 1, "late_gap");
    hold(1'b1, 2, "late_p2");
    hold(1'b0, 8, "late_rel");

    // Release on the long-press boundary, and one cycle past it.
    hold(1'b1, LD, "edge_short");
    hold(1'b0, 8, "edge_short_rel");
    hold(1'b1, LD + 1, "edge_long");
    hold(1'b0, 8, "edge_long_rel");

    // Button held through reset release.
    apply_reset(1'b1, "s5_rst");
    hold(1'b1, 4, "s5_stuck");
    hold(1'b0, 1, "s5_fall");
    hold(1'b1, 3, "s5_press");
    hold(1'b0, 8, "s5_rel");

    // Reset in the LONG state.
    hold(1'b1, 12, "s6_long");
    apply_reset(1'b0, "s6_rst");
    hold(1'b0, 4, "s6_after");

    // Random runs of pressed/released levels with occasional resets.
    begin
      logic lvl;
      lvl = 1'b0;
      for (int r = 0; r < 250; r++) begin
        if ($urandom_range(0, 39) == 0) apply_reset(1'($urandom_range(0, 1)), "rnd_rst");
        lvl = ~lvl;
        hold(lvl, $urandom_range(1, 13), "rnd");
      end
    end
    hold(1'b0, 8, "tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
